// File: rtl/shift_decode_stage_if.sv
// shift_decode_stage_if
// Purpose : bundles the upstream handshake, operand, forwarding and flush
//           inputs together with the registered shifter-facing outputs of
//           the ID/EX shift decode stage.
// Ports   : none; the signals are carried through the modports.
//           slave  - view used by shift_decode_stage (consumes instruction
//                    and operands, drives shifter inputs and status).
//           master - view used by whatever drives the stage (upstream
//                    pipeline plus EX stage, or a testbench).
// Params  : CNT_W - width of shift_count; must match the stage's CNT_W.
interface shift_decode_stage_if #(
    parameter int CNT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [31:0]      in_rs_val;
    logic [31:0]      in_rt_val;
    logic             exmem_regwrite;
    logic [4:0]       exmem_rd;
    logic [31:0]      exmem_value;
    logic             memwb_regwrite;
    logic [4:0]       memwb_rd;
    logic [31:0]      memwb_value;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      sh_in;
    logic [1:0]       sh_op;
    logic [4:0]       sh_amt;
    logic [4:0]       out_rd;
    logic             out_is_shift;
    logic [CNT_W-1:0] shift_count;

    modport slave (
        input  in_valid, in_instr, in_rs_val, in_rt_val,
        input  exmem_regwrite, exmem_rd, exmem_value,
        input  memwb_regwrite, memwb_rd, memwb_value,
        input  flush, out_ready,
        output in_ready, out_valid, sh_in, sh_op, sh_amt,
        output out_rd, out_is_shift, shift_count
    );

    modport master (
        output in_valid, in_instr, in_rs_val, in_rt_val,
        output exmem_regwrite, exmem_rd, exmem_value,
        output memwb_regwrite, memwb_rd, memwb_value,
        output flush, out_ready,
        input  in_ready, out_valid, sh_in, sh_op, sh_amt,
        input  out_rd, out_is_shift, shift_count
    );
endinterface

// File: rtl/shift_decode_stage.sv
// shift_decode_stage
// Purpose : ID/EX stage feeding the EX shifter. Decodes the six SPECIAL
//           shift instructions, picks forwarded rs/rt values, and registers
//           the shifter inputs behind a valid/ready handshake with flush.
//           Counts the shift instructions it issues.
// Ports   : clock - rising-edge clock
//           reset - asynchronous, active-low reset
//           bus   - shift_decode_stage_if.slave: in_valid/in_ready/in_instr,
//                   rs/rt register-file values, EX/MEM and MEM/WB forwarding
//                   sources, flush, out_valid/out_ready, sh_in, sh_op,
//                   sh_amt, out_rd, out_is_shift, shift_count
// Params  : FWD_EN - 1 enables EX/MEM and MEM/WB forwarding
//           CNT_W  - width of shift_count (wraps modulo 2^CNT_W)
module shift_decode_stage #(
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_W  = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    shift_decode_stage_if.slave   bus
);
    localparam logic [1:0] OP_SRL = 2'd0;
    localparam logic [1:0] OP_SRA = 2'd1;
    localparam logic [1:0] OP_SLL = 2'd2;

    logic [5:0]       w_opcode;
    logic [5:0]       w_funct;
    logic [4:0]       w_rsIdx;
    logic [4:0]       w_rtIdx;
    logic [4:0]       w_rdIdx;
    logic [4:0]       w_shamt;
    logic [31:0]      w_rsFwd;
    logic [31:0]      w_rtFwd;
    logic             w_isShift;
    logic [1:0]       w_op;
    logic [4:0]       w_amt;
    logic [31:0]      w_shIn;
    logic             w_accept;
    logic             w_unusedRsHigh;

    logic             r_valid;
    logic [31:0]      r_shIn;
    logic [1:0]       r_shOp;
    logic [4:0]       r_shAmt;
    logic [4:0]       r_rd;
    logic             r_isShift;
    logic [CNT_W-1:0] r_count;

    assign w_opcode = bus.in_instr[31:26];
    assign w_rsIdx  = bus.in_instr[25:21];
    assign w_rtIdx  = bus.in_instr[20:16];
    assign w_rdIdx  = bus.in_instr[15:11];
    assign w_shamt  = bus.in_instr[10:6];
    assign w_funct  = bus.in_instr[5:0];

    // Only the low five bits of rs ever matter (variable shift amount).
    assign w_unusedRsHigh = ^w_rsFwd[31:5];

    // Operand forwarding: the younger EX/MEM result beats MEM/WB, and
    // register 0 is hard-wired so it is never a forwarding target.
    always_comb begin
        w_rsFwd = bus.in_rs_val;
        if (FWD_EN && bus.exmem_regwrite && (bus.exmem_rd != 5'd0) && (bus.exmem_rd == w_rsIdx))
            w_rsFwd = bus.exmem_value;
        else if (FWD_EN && bus.memwb_regwrite && (bus.memwb_rd != 5'd0) && (bus.memwb_rd == w_rsIdx))
            w_rsFwd = bus.memwb_value;
    end

    always_comb begin
        w_rtFwd = bus.in_rt_val;
        if (FWD_EN && bus.exmem_regwrite && (bus.exmem_rd != 5'd0) && (bus.exmem_rd == w_rtIdx))
            w_rtFwd = bus.exmem_value;
        else if (FWD_EN && bus.memwb_regwrite && (bus.memwb_rd != 5'd0) && (bus.memwb_rd == w_rtIdx))
            w_rtFwd = bus.memwb_value;
    end

    // Shift decode. Non-shift words fall through with all shifter fields
    // zeroed so EX sees a harmless SRL of 0 by 0.
    always_comb begin
        w_isShift = 1'b0;
        w_op      = OP_SRL;
        w_amt     = 5'd0;
        if (w_opcode == 6'd0) begin
            case (w_funct)
                6'h00: begin w_isShift = 1'b1; w_op = OP_SLL; w_amt = w_shamt;      end
                6'h02: begin w_isShift = 1'b1; w_op = OP_SRL; w_amt = w_shamt;      end
                6'h03: begin w_isShift = 1'b1; w_op = OP_SRA; w_amt = w_shamt;      end
                6'h04: begin w_isShift = 1'b1; w_op = OP_SLL; w_amt = w_rsFwd[4:0]; end
                6'h06: begin w_isShift = 1'b1; w_op = OP_SRL; w_amt = w_rsFwd[4:0]; end
                6'h07: begin w_isShift = 1'b1; w_op = OP_SRA; w_amt = w_rsFwd[4:0]; end
                default: ;
            endcase
        end
    end

    assign w_shIn = w_isShift ? w_rtFwd : 32'd0;

    assign bus.in_ready = !r_valid || bus.out_ready;
    assign w_accept     = bus.in_valid && bus.in_ready && !bus.flush;

    // Output register. Flush only drops valid and leaves the payload alone;
    // a plain consume does the same. Payload and counter move on accept only,
    // so operands are frozen while the EX stage stalls.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid   <= 1'b0;
            r_shIn    <= 32'd0;
            r_shOp    <= 2'd0;
            r_shAmt   <= 5'd0;
            r_rd      <= 5'd0;
            r_isShift <= 1'b0;
            r_count   <= '0;
        end else if (bus.flush) begin
            r_valid   <= 1'b0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_shIn    <= w_shIn;
            r_shOp    <= w_op;
            r_shAmt   <= w_amt;
            r_rd      <= w_rdIdx;
            r_isShift <= w_isShift;
            r_count   <= r_count + {{(CNT_W-1){1'b0}}, w_isShift};
        end else if (bus.out_ready) begin
            r_valid   <= 1'b0;
        end
    end

    assign bus.out_valid    = r_valid;
    assign bus.sh_in        = r_shIn;
    assign bus.sh_op        = r_shOp;
    assign bus.sh_amt       = r_shAmt;
    assign bus.out_rd       = r_rd;
    assign bus.out_is_shift = r_isShift;
    assign bus.shift_count  = r_count;
endmodule

// File: tb/tb_shift_decode_stage.sv
// tb_shift_decode_stage
// Purpose : directed self-checking bench for shift_decode_stage. A narrow
//           shift counter is used so wrap-around is reachable quickly.
// Ports   : none (top-level bench).
module tb_shift_decode_stage;
    localparam int CNT_W = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    shift_decode_stage_if #(.CNT_W(CNT_W)) bus ();

    shift_decode_stage #(
        .FWD_EN (1'b1),
        .CNT_W  (CNT_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, period 10.
    always #5 clock = ~clock;

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Compares every registered output of the stage.
    task automatic checkStage(input string tag, input logic valid, input logic [31:0] shIn,
                              input logic [1:0] op, input logic [4:0] amt, input logic [4:0] rd,
                              input logic isShift, input logic [31:0] count);
        checkOutput($sformatf("%s.out_valid", tag),    32'(bus.out_valid),    32'(valid));
        checkOutput($sformatf("%s.sh_in", tag),        bus.sh_in,             shIn);
        checkOutput($sformatf("%s.sh_op", tag),        32'(bus.sh_op),        32'(op));
        checkOutput($sformatf("%s.sh_amt", tag),       32'(bus.sh_amt),       32'(amt));
        checkOutput($sformatf("%s.out_rd", tag),       32'(bus.out_rd),       32'(rd));
        checkOutput($sformatf("%s.out_is_shift", tag), 32'(bus.out_is_shift), 32'(isShift));
        checkOutput($sformatf("%s.shift_count", tag),  32'(bus.shift_count),  count);
    endtask

    // Presents one instruction with its register-file operands.
    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] rsVal, input logic [31:0] rtVal);
        bus.in_valid  = 1'b1;
        bus.in_instr  = instr;
        bus.in_rs_val = rsVal;
        bus.in_rt_val = rtVal;
    endtask

    task automatic clearForwarding();
        bus.exmem_regwrite = 1'b0;
        bus.exmem_rd       = 5'd0;
        bus.exmem_value    = 32'd0;
        bus.memwb_regwrite = 1'b0;
        bus.memwb_rd       = 5'd0;
        bus.memwb_value    = 32'd0;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_instr  = 32'd0;
        bus.in_rs_val = 32'd0;
        bus.in_rt_val = 32'd0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        clearForwarding();

        // T1: reset held, then released.
        tick();
        checkStage("T1.inReset", 1'b0, 32'd0, 2'd0, 5'd0, 5'd0, 1'b0, 0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        checkStage("T1.released", 1'b0, 32'd0, 2'd0, 5'd0, 5'd0, 1'b0, 0);
        checkOutput("T1.in_ready", 32'(bus.in_ready), 32'd1);

        // T2: sll $8,$8,2
        applyStimulus(32'h0008_4080, 32'd0, 32'd3);
        tick();
        checkStage("T2.sll", 1'b1, 32'd3, 2'd2, 5'd2, 5'd8, 1'b1, 1);

        // T3: srav $3,$5,$4 from register-file values
        applyStimulus(32'h0085_1807, 32'h23, 32'hF000_0000);
        tick();
        checkStage("T3.srav", 1'b1, 32'hF000_0000, 2'd1, 5'd3, 5'd3, 1'b1, 2);

        // T4a: both stages target rt=$5, EX/MEM wins
        bus.exmem_regwrite = 1'b1; bus.exmem_rd = 5'd5; bus.exmem_value = 32'h8000_0000;
        bus.memwb_regwrite = 1'b1; bus.memwb_rd = 5'd5; bus.memwb_value = 32'd1;
        tick();
        checkStage("T4.exmemWins", 1'b1, 32'h8000_0000, 2'd1, 5'd3, 5'd3, 1'b1, 3);

        // T4b: EX/MEM not writing; MEM/WB supplies rs=$4 -> amount 31
        bus.exmem_regwrite = 1'b0;
        bus.memwb_regwrite = 1'b1; bus.memwb_rd = 5'd4; bus.memwb_value = 32'h0000_003F;
        tick();
        checkStage("T4.memwbRs", 1'b1, 32'hF000_0000, 2'd1, 5'd31, 5'd3, 1'b1, 4);

        // T4c: srav $3,$0,$4 with both stages writing $0 -> never forwarded
        clearForwarding();
        bus.exmem_regwrite = 1'b1; bus.exmem_rd = 5'd0; bus.exmem_value = 32'd7;
        bus.memwb_regwrite = 1'b1; bus.memwb_rd = 5'd0; bus.memwb_value = 32'd9;
        applyStimulus(32'h0080_1807, 32'h23, 32'd0);
        tick();
        checkStage("T4.rdZero", 1'b1, 32'd0, 2'd1, 5'd3, 5'd3, 1'b1, 5);
        clearForwarding();

        // Remaining shift encodings
        applyStimulus(32'h0008_4082, 32'd0, 32'd3);
        tick();
        checkStage("srl", 1'b1, 32'd3, 2'd0, 5'd2, 5'd8, 1'b1, 6);
        applyStimulus(32'h0008_4083, 32'd0, 32'h8000_0001);
        tick();
        checkStage("sra", 1'b1, 32'h8000_0001, 2'd1, 5'd2, 5'd8, 1'b1, 7);
        applyStimulus(32'h0085_1804, 32'h25, 32'd1);
        tick();
        checkStage("sllv", 1'b1, 32'd1, 2'd2, 5'd5, 5'd3, 1'b1, 8);
        applyStimulus(32'h0085_1806, 32'hFFFF_FFE0, 32'hA);
        tick();
        checkStage("srlv", 1'b1, 32'hA, 2'd0, 5'd0, 5'd3, 1'b1, 9);

        // Non-shift words pass with zeroed shifter fields
        applyStimulus(32'h0085_1820, 32'h23, 32'hF);
        tick();
        checkStage("add", 1'b1, 32'd0, 2'd0, 5'd0, 5'd3, 1'b0, 9);
        applyStimulus(32'h2008_4080, 32'd0, 32'd3);
        tick();
        checkStage("opcodeNonZero", 1'b1, 32'd0, 2'd0, 5'd0, 5'd8, 1'b0, 9);

        // Consume without new accept: valid drops, payload kept
        bus.in_valid = 1'b0;
        tick();
        checkStage("consume", 1'b0, 32'd0, 2'd0, 5'd0, 5'd8, 1'b0, 9);

        // T5: accept with EX stalled, then hold for 3 cycles
        bus.out_ready = 1'b0;
        applyStimulus(32'h0008_4080, 32'd0, 32'd3);
        tick();
        checkStage("T5.accept", 1'b1, 32'd3, 2'd2, 5'd2, 5'd8, 1'b1, 10);
        applyStimulus(32'h0008_4082, 32'd0, 32'h55);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("T5.in_ready.%0d", i), 32'(bus.in_ready), 32'd0);
            tick();
            checkStage($sformatf("T5.hold%0d", i), 1'b1, 32'd3, 2'd2, 5'd2, 5'd8, 1'b1, 10);
        end
        bus.out_ready = 1'b1;
        #1;
        checkOutput("T5.in_readyReleased", 32'(bus.in_ready), 32'd1);
        tick();
        checkStage("T5.nextWord", 1'b1, 32'h55, 2'd0, 5'd2, 5'd8, 1'b1, 11);

        // T6: flush discards an acceptable word
        applyStimulus(32'h0085_1804, 32'h23, 32'd1);
        bus.flush = 1'b1;
        tick();
        checkOutput("T6.flushValid", 32'(bus.out_valid), 32'd0);
        checkOutput("T6.flushCount", 32'(bus.shift_count), 32'd11);
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        checkStage("T6.accept", 1'b1, 32'd1, 2'd2, 5'd3, 5'd3, 1'b1, 12);
        // Flush of a held word
        bus.flush = 1'b1;
        tick();
        checkOutput("T6.flushHeldValid", 32'(bus.out_valid), 32'd0);
        checkOutput("T6.flushHeldCount", 32'(bus.shift_count), 32'd12);
        bus.flush = 1'b0;
        tick();
        checkStage("T6.reaccept", 1'b1, 32'd1, 2'd2, 5'd3, 5'd3, 1'b1, 13);
        bus.in_valid = 1'b0;
        tick();
        checkStage("T6.held", 1'b1, 32'd1, 2'd2, 5'd3, 5'd3, 1'b1, 13);
        // Asynchronous reset mid-cycle during the hold
        #2;
        reset = 1'b0;
        #1;
        checkStage("T6.asyncReset", 1'b0, 32'd0, 2'd0, 5'd0, 5'd0, 1'b0, 0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        checkOutput("T6.in_readyAfterReset", 32'(bus.in_ready), 32'd1);

        // Counter wrap: 16 shifts on a 4-bit counter return it to 0
        bus.out_ready = 1'b1;
        applyStimulus(32'h0008_4080, 32'd0, 32'd3);
        repeat (16) tick();
        checkStage("wrap16", 1'b1, 32'd3, 2'd2, 5'd2, 5'd8, 1'b1, 0);
        tick();
        checkOutput("wrap17", 32'(bus.shift_count), 32'd1);
        bus.in_valid = 1'b0;
        tick();
        checkOutput("finalDrain", 32'(bus.out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
